// File: rtl/soc_system_mem_tester_pkg.sv
// Shared definitions for the Avalon-MM memory tester: FSM state encoding,
// pattern LFSR polynomial, default seed and the LFSR next-state function.
package soc_system_mem_tester_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FIN   = 3'd4
  } state_e;

  // Right-shifting Galois form of x^32+x^22+x^2+x+1 (taps 32,22,2,1).
  localparam logic [31:0] LFSR_POLY         = 32'h8020_0003;
  // An all-zero state would lock the LFSR, so a zero seed is replaced by this.
  localparam logic [31:0] LFSR_DEFAULT_SEED = 32'h0000_0001;
  // Outstanding-read counter width; covers MAX_PEND up to 15.
  localparam int          PEND_W            = 4;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    lfsr_next = s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

endpackage

// File: rtl/soc_system_mem_tester_lfsr.sv
// 32-bit pattern generator used once for write data and once for read checking.
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset (state resets to 0)
//   load, seed    load seed into the state (has priority over step)
//   step          advance one LFSR step
//   state         current pattern word
module soc_system_mem_tester_lfsr
  import soc_system_mem_tester_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] state
);

  logic [31:0] state_q;
  logic [31:0] state_d;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = seed;
    end else if (step) begin
      state_d = lfsr_next(state_q);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/soc_system_mem_tester.sv
// Avalon-MM master that writes an LFSR pattern over a word range of a memory
// slave, reads it back with pipelined reads and reports the result.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   start, abort        control strobes (start sampled only in IDLE)
//   base, count, seed   run parameters, sampled with start
//   busy, done, pass, aborted, err_cnt, err_addr   status
//   avm_*               Avalon-MM master port (all commands registered)
module soc_system_mem_tester
  import soc_system_mem_tester_pkg::*;
#(
  parameter int ADDR_W   = 13,
  parameter int MAX_PEND = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   count,
  input  logic [31:0]       seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              aborted,
  output logic [15:0]       err_cnt,
  output logic [ADDR_W-1:0] err_addr,
  output logic [ADDR_W-1:0] avm_address,
  output logic [3:0]        avm_byteenable,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic              avm_read,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  input  logic              avm_waitrequest
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   REM_ONE  = (ADDR_W + 1)'(1);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PEND);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_e              state_q, state_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic                aborted_q, aborted_d;
  logic [15:0]         err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
  logic                wr_q, wr_d;
  logic                rd_q, rd_d;
  logic                cs_q, cs_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [ADDR_W:0]     rem_q, rem_d;
  logic [PEND_W-1:0]   pend_q, pend_d;
  logic [ADDR_W-1:0]   ret_addr_q, ret_addr_d;

  logic                lfsr_load;
  logic                wr_step;
  logic                chk_step;
  logic [31:0]         seed_eff;
  logic [31:0]         wr_state;
  logic [31:0]         chk_state;
  logic                wr_acc;
  logic                rd_acc;
  logic                rdv_run;

  assign seed_eff = (seed == 32'h0) ? LFSR_DEFAULT_SEED : seed;
  assign wr_acc   = wr_q & ~avm_waitrequest;
  assign rd_acc   = rd_q & ~avm_waitrequest;
  // Read returns only count while a run is live; a reset run ignores stragglers.
  assign rdv_run  = avm_readdatavalid &
                    ((state_q == ST_WRITE) | (state_q == ST_READ) | (state_q == ST_DRAIN));

  soc_system_mem_tester_lfsr u_wr_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (lfsr_load),
    .seed    (seed_eff),
    .step    (wr_step),
    .state   (wr_state)
  );

  soc_system_mem_tester_lfsr u_chk_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (lfsr_load),
    .seed    (seed_eff),
    .step    (chk_step),
    .state   (chk_state)
  );

  // Outstanding reads: an accept and a return in the same cycle cancel out.
  always_comb begin
    pend_d = pend_q;
    if (rd_acc && !rdv_run) begin
      pend_d = pend_q + PEND_W'(1);
    end else if (!rd_acc && rdv_run && (pend_q != '0)) begin
      pend_d = pend_q - PEND_W'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    aborted_d  = aborted_q;
    err_cnt_d  = err_cnt_q;
    err_addr_d = err_addr_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    addr_d     = addr_q;
    base_d     = base_q;
    count_d    = count_q;
    rem_d      = rem_q;
    ret_addr_d = ret_addr_q;
    lfsr_load  = 1'b0;
    wr_step    = 1'b0;
    chk_step   = 1'b0;

    // Check stage: every return is compared against the check LFSR and the
    // result lands in err_cnt/err_addr on the following cycle.
    if (rdv_run) begin
      chk_step   = 1'b1;
      ret_addr_d = ret_addr_q + ADDR_ONE;
      if (avm_readdata != chk_state) begin
        if (err_cnt_q == 16'd0) begin
          err_addr_d = ret_addr_q;
        end
        err_cnt_d = sat_inc16(err_cnt_q);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          lfsr_load  = 1'b1;
          base_d     = base;
          count_d    = count;
          rem_d      = count;
          ret_addr_d = base;
          addr_d     = base;
          err_cnt_d  = 16'd0;
          err_addr_d = '0;
          aborted_d  = 1'b0;
          pass_d     = 1'b0;
          if (count == '0) begin
            state_d = ST_FIN;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else begin
            state_d = ST_WRITE;
            busy_d  = 1'b1;
            wr_d    = 1'b1;
          end
        end
      end

      ST_WRITE: begin
        if (wr_acc) begin
          wr_step = 1'b1;
          addr_d  = addr_q + ADDR_ONE;
          rem_d   = rem_q - REM_ONE;
        end
        if (abort) begin
          wr_d      = 1'b0;
          aborted_d = 1'b1;
          state_d   = ST_DRAIN;
        end else if (wr_acc && (rem_q == REM_ONE)) begin
          // Last write accepted: first read goes out on the very next cycle.
          wr_d    = 1'b0;
          rd_d    = 1'b1;
          addr_d  = base_q;
          rem_d   = count_q;
          state_d = ST_READ;
        end
      end

      ST_READ: begin
        if (rd_acc) begin
          addr_d = addr_q + ADDR_ONE;
          rem_d  = rem_q - REM_ONE;
        end
        if (abort) begin
          rd_d      = 1'b0;
          aborted_d = 1'b1;
          state_d   = ST_DRAIN;
        end else if (rd_acc && (rem_q == REM_ONE)) begin
          rd_d    = 1'b0;
          state_d = ST_DRAIN;
        end else if (!rd_q || rd_acc) begin
          // A stalled read stays on the bus; otherwise issue while the
          // outstanding count (including this cycle's accept) has room.
          rd_d = (rem_d != '0) && (pend_d < PEND_MAX);
        end
      end

      ST_DRAIN: begin
        if (abort) begin
          aborted_d = 1'b1;
        end
        if (pend_q == '0) begin
          state_d = ST_FIN;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pass_d  = (err_cnt_d == 16'd0) && !aborted_d;
        end
      end

      ST_FIN: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    cs_d = wr_d | rd_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      aborted_q  <= 1'b0;
      err_cnt_q  <= '0;
      err_addr_q <= '0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      cs_q       <= 1'b0;
      addr_q     <= '0;
      base_q     <= '0;
      count_q    <= '0;
      rem_q      <= '0;
      pend_q     <= '0;
      ret_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      aborted_q  <= aborted_d;
      err_cnt_q  <= err_cnt_d;
      err_addr_q <= err_addr_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cs_q       <= cs_d;
      addr_q     <= addr_d;
      base_q     <= base_d;
      count_q    <= count_d;
      rem_q      <= rem_d;
      pend_q     <= pend_d;
      ret_addr_q <= ret_addr_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign aborted        = aborted_q;
  assign err_cnt        = err_cnt_q;
  assign err_addr       = err_addr_q;
  assign avm_address    = addr_q;
  assign avm_byteenable = 4'hF;
  assign avm_chipselect = cs_q;
  assign avm_write      = wr_q;
  assign avm_read       = rd_q;
  assign avm_writedata  = wr_state;

endmodule

// File: tb/tb_soc_system_mem_tester.sv
// Bench for soc_system_mem_tester: memory slave model with programmable read
// latency, random waitrequest and word corruption; table of runs plus
// hand-written abort and reset sequences.
module tb_soc_system_mem_tester;

  localparam int AW   = 13;
  localparam int MAXP = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start, abort;
  logic [AW-1:0] base;
  logic [AW:0]   count;
  logic [31:0]   seed;
  logic          busy, done, pass, aborted;
  logic [15:0]   err_cnt;
  logic [AW-1:0] err_addr, avm_address;
  logic [3:0]    avm_byteenable;
  logic          avm_chipselect, avm_write, avm_read;
  logic [31:0]   avm_writedata, avm_readdata;
  logic          avm_readdatavalid;
  logic          avm_waitrequest;

  soc_system_mem_tester #(.ADDR_W(AW), .MAX_PEND(MAXP)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .base(base), .count(count), .seed(seed),
    .busy(busy), .done(done), .pass(pass), .aborted(aborted),
    .err_cnt(err_cnt), .err_addr(err_addr),
    .avm_address(avm_address), .avm_byteenable(avm_byteenable),
    .avm_chipselect(avm_chipselect), .avm_write(avm_write), .avm_read(avm_read),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid), .avm_waitrequest(avm_waitrequest)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference pattern: x^32+x^22+x^2+x+1; the bit leaving the LSB feeds back
  // into taps 32,22,2,1 (bits 31,21,1,0 after the shift).
  function automatic logic [31:0] ref_next(input logic [31:0] s);
    logic [31:0] r;
    r = s >> 1;
    if (s[0]) begin
      r[31] = ~r[31]; r[21] = ~r[21]; r[1] = ~r[1]; r[0] = ~r[0];
    end
    return r;
  endfunction

  // ---------------- slave model ----------------
  int          lat     = 1;
  bit          wait_en = 1'b0;
  int          cor0    = -1;
  int          cor1    = -1;
  logic [31:0] mem [0:(1<<AW)-1];
  logic        lv  [0:7];
  logic [31:0] ld  [0:7];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avm_waitrequest <= 1'b0;
      for (int k = 0; k < 8; k++) begin
        lv[k] <= 1'b0;
        ld[k] <= 32'h0;
      end
    end else begin
      avm_waitrequest <= wait_en ? 1'($urandom_range(0, 1)) : 1'b0;
      if (avm_write && !avm_waitrequest)
        mem[avm_address] <= ((int'(avm_address) == cor0) || (int'(avm_address) == cor1)) ?
                            (avm_writedata ^ 32'h1) : avm_writedata;
      lv[0] <= avm_read && !avm_waitrequest;
      ld[0] <= mem[avm_address];
      for (int k = 1; k < 8; k++) begin
        lv[k] <= lv[k-1];
        ld[k] <= ld[k-1];
      end
    end
  end

  assign avm_readdatavalid = lv[lat-1];
  assign avm_readdata      = ld[lat-1];

  // ---------------- bus monitor ----------------
  logic [AW-1:0] wq_a [$];
  logic [31:0]   wq_d [$];
  logic [AW-1:0] rq_a [$];
  int            viol = 0;
  int            done_cnt = 0;
  int            cyc = 0;
  int            pend_mon = 0;
  int            pend_np;
  logic          hold_q = 1'b0;
  logic [46:0]   sig_q = '0;
  logic [46:0]   sig;
  logic          proto_bad;

  assign sig     = {avm_write, avm_read, avm_address, avm_writedata};
  assign pend_np = pend_mon + int'(avm_read && !avm_waitrequest) - int'(avm_readdatavalid);
  assign proto_bad = (avm_write && avm_read) ||
                     (avm_chipselect != (avm_write || avm_read)) ||
                     (avm_byteenable != 4'hF) ||
                     (hold_q && (sig != sig_q)) ||
                     (pend_np > MAXP) || (pend_np < 0);

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset_n) begin
      pend_mon <= 0;
      hold_q   <= 1'b0;
    end else begin
      if (avm_write && !avm_waitrequest) begin
        wq_a.push_back(avm_address);
        wq_d.push_back(avm_writedata);
      end
      if (avm_read && !avm_waitrequest) rq_a.push_back(avm_address);
      if (proto_bad) viol <= viol + 1;
      if (done) done_cnt <= done_cnt + 1;
      pend_mon <= pend_np;
      hold_q   <= (avm_write || avm_read) && avm_waitrequest;
      sig_q    <= sig;
    end
  end

  // ---------------- run table ----------------
  typedef struct {
    int          base;
    int          cnt;
    logic [31:0] seed;
    int          lat;
    bit          wen;
    int          c0;
    int          c1;
    int          exp_done;   // -1: latency not checked
    int          exp_err;
    int          exp_eaddr;
  } vec_t;

  vec_t vecs [$];

  function automatic void model_errs(inout vec_t v);
    v.exp_err   = 0;
    v.exp_eaddr = 0;
    for (int i = 0; i < v.cnt; i++) begin
      int a;
      a = (v.base + i) % (1 << AW);
      if (a == v.c0 || a == v.c1) begin
        if (v.exp_err == 0) v.exp_eaddr = a;
        v.exp_err++;
      end
    end
  endfunction

  task automatic run_vec(input vec_t v, input int id);
    int w0, r0, v0, t0, t1, werr, rerr;
    bit seen;
    logic [31:0] p;
    string tag;
    tag = $sformatf("v%0d", id);
    cor0 = v.c0; cor1 = v.c1; lat = v.lat; wait_en = v.wen;
    @(negedge clk);
    w0 = wq_a.size(); r0 = rq_a.size(); v0 = viol;
    base = AW'(v.base); count = (AW+1)'(v.cnt); seed = v.seed; start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    if (v.cnt > 0) chk({tag, "_busy_c1"}, busy, 1);
    seen = 1'b0;
    for (int i = 0; i < 20000 && !seen; i++) begin
      if (done) seen = 1'b1;
      else @(negedge clk);
    end
    t1 = cyc;
    chk({tag, "_done_seen"}, seen, 1);
    if (seen) begin
      if (v.exp_done >= 0) chk({tag, "_done_cycle"}, t1 - t0, v.exp_done);
      chk({tag, "_busy_at_done"}, busy, 0);
      chk({tag, "_err_cnt"}, err_cnt, v.exp_err);
      chk({tag, "_err_addr"}, err_addr, v.exp_eaddr);
      chk({tag, "_pass"}, pass, (v.exp_err == 0) ? 1 : 0);
      chk({tag, "_aborted"}, aborted, 0);
      werr = 0;
      if (wq_a.size() - w0 != v.cnt) werr++;
      else begin
        p = (v.seed == 32'h0) ? 32'h1 : v.seed;
        for (int i = 0; i < v.cnt; i++) begin
          if (wq_a[w0+i] != AW'((v.base + i) % (1 << AW)) || wq_d[w0+i] != p) werr++;
          p = ref_next(p);
        end
      end
      chk({tag, "_write_seq_errs"}, werr, 0);
      rerr = 0;
      if (rq_a.size() - r0 != v.cnt) rerr++;
      else
        for (int i = 0; i < v.cnt; i++)
          if (rq_a[r0+i] != AW'((v.base + i) % (1 << AW))) rerr++;
      chk({tag, "_read_seq_errs"}, rerr, 0);
      chk({tag, "_protocol_viol"}, viol - v0, 0);
      @(negedge clk);
      chk({tag, "_done_pulse"}, done, 0);
      chk({tag, "_pass_held"}, pass, (v.exp_err == 0) ? 1 : 0);
    end
  endtask

  initial begin
    vec_t v;
    int w0, r0, t0, dc0, werr;
    bit seen;
    logic [31:0] p;
    start = 1'b0; abort = 1'b0; base = '0; count = '0; seed = '0;
    repeat (3) @(negedge clk);
    chk("rst_status", {busy, done, pass, aborted, err_cnt, err_addr}, 0);
    chk("rst_bus", {avm_write, avm_read, avm_chipselect, avm_address, avm_writedata}, 0);
    reset_n = 1'b1;
    @(negedge clk);

    //                base  cnt  seed           lat wen c0  c1  done err eaddr
    vecs.push_back('{0,    16,  32'h1,          1,  0, -1, -1, 35,  0,  0});
    vecs.push_back('{8190, 4,   32'hDEADBEEF,   1,  0, -1, -1, 11,  0,  0});
    vecs.push_back('{0,    16,  32'h0000_1234,  1,  0,  5,  9, 35,  2,  5});
    vecs.push_back('{300,  64,  32'hCAFE_F00D,  3,  1, -1, -1, -1,  0,  0});
    vecs.push_back('{10,   8,   32'h0,          2,  0, -1, -1, 20,  0,  0});
    vecs.push_back('{0,    0,   32'h5,          1,  0, -1, -1,  1,  0,  0});
    vecs.push_back('{8191, 3,   32'h0BAD_F00D,  4,  0,  0, -1, 12,  1,  0});
    for (int r = 0; r < 6; r++) begin
      v.cnt  = $urandom_range(1, 40);
      v.base = $urandom_range(0, (1 << AW) - 1);
      v.seed = $urandom;
      v.lat  = $urandom_range(1, 4);
      v.wen  = 1'($urandom_range(0, 1));
      v.c0   = ($urandom_range(0, 1) == 1) ? (v.base + $urandom_range(0, v.cnt - 1)) % (1 << AW) : -1;
      v.c1   = -1;
      v.exp_done = (!v.wen && v.lat <= MAXP - 1) ? 2 * v.cnt + v.lat + 2 : -1;
      model_errs(v);
      vecs.push_back(v);
    end
    foreach (vecs[i]) run_vec(vecs[i], i);

    // Abort while the 10th of 32 reads is on the bus.
    cor0 = -1; cor1 = -1; lat = 1; wait_en = 1'b0;
    @(negedge clk);
    w0 = wq_a.size(); r0 = rq_a.size();
    base = AW'(1000); count = (AW+1)'(32); seed = 32'h1357_9BDF; start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    repeat (41) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      if (done) seen = 1'b1;
      else @(negedge clk);
    end
    chk("abort_done_seen", seen, 1);
    chk("abort_done_cycle", cyc - t0, 45);
    chk("abort_writes", wq_a.size() - w0, 32);
    chk("abort_reads", rq_a.size() - r0, 10);
    chk("abort_aborted", aborted, 1);
    chk("abort_pass", pass, 0);
    chk("abort_err_cnt", err_cnt, 0);
    chk("abort_drained", pend_mon, 0);

    // Second start during busy is ignored; reset mid-WRITE kills the run.
    @(negedge clk);
    w0 = wq_a.size();
    base = AW'(0); count = (AW+1)'(50); seed = 32'd77; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    base = AW'(100); count = (AW+1)'(5); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_ignored_start", busy, 1);
    repeat (5) @(negedge clk);
    dc0 = done_cnt;
    werr = 0;
    if (wq_a.size() - w0 < 8) werr++;
    else begin
      p = 32'd77;
      for (int i = 0; i < 8; i++) begin
        if (wq_a[w0+i] != AW'(i) || wq_d[w0+i] != p) werr++;
        p = ref_next(p);
      end
    end
    chk("restart_ignored_write_errs", werr, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("midrun_rst_status", {busy, done, pass, aborted, err_cnt, err_addr}, 0);
    chk("midrun_rst_bus", {avm_write, avm_read, avm_chipselect, avm_address, avm_writedata}, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("no_done_after_rst", done_cnt - dc0, 0);
    chk("idle_after_rst", busy, 0);

    run_vec(vecs[1], 99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/soc_system_mem_tester.md
# soc_system_mem_tester

Avalon-MM master that exercises an on-chip memory slave: writes a pseudo-random 32-bit pattern across a programmable word range, reads it back with pipelined reads, and reports pass/fail, error count and first failing address. Sits on the master side of the memory's Avalon-MM port (or behind an interconnect) and is controlled by a simple start/abort strobe interface from HPS-side control registers.

## Interface
- ADDR_W, 13: word-address width (8192 words).
- MAX_PEND, 4: maximum outstanding reads, 1..15.
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle strobe; sampled only in IDLE.
- abort  in  1  one-cycle strobe; stops issuing commands.
- base  in  ADDR_W  first word address; sampled with start.
- count  in  ADDR_W+1  words to test, 0..2^ADDR_W; sampled with start.
- seed  in  32  LFSR seed; 0 replaced by 32'h1; sampled with start.
- busy  out  1  high from cycle after accepted start until done.
- done  out  1  one-cycle pulse at end of run.
- pass  out  1  valid from done until next start: err_cnt==0 and not aborted.
- aborted  out  1  run ended by abort.
- err_cnt  out  16  mismatching words, saturates at 16'hFFFF.
- err_addr  out  ADDR_W  address of first mismatch.
- avm_address  out  ADDR_W  word address.
- avm_byteenable  out  4  constant 4'hF.
- avm_chipselect  out  1  high with read or write.
- avm_write / avm_read  out  1  command strobes, never both high.
- avm_writedata  out  32  pattern word.
- avm_readdata  in  32  read data.
- avm_readdatavalid  in  1  readdata qualifier.
- avm_waitrequest  in  1  slave stall; tie low for fixed-latency memory.

## Operation
- States: IDLE, WRITE, READ, DRAIN, FIN.
- IDLE: start with count>0 → WRITE, latch base/count/seed, clear err_cnt/err_addr/aborted. start with count==0 → FIN directly, no bus activity.
- Pattern: Galois LFSR, polynomial x^32+x^22+x^2+x+1; word i = LFSR state after i steps from seed (word 0 = seed). Write LFSR and check LFSR independent, both restarted from seed.
- Address: base+i modulo 2^ADDR_W (wraps at top of memory).
- WRITE: command held stable while avm_waitrequest high; accepted when write & ~waitrequest → advance index/LFSR. Last accepted write → READ.
- READ: issue read when remaining>0 and pend<MAX_PEND; accept on ~waitrequest. pend +1 on accept, −1 on readdatavalid, unchanged when both. Each readdatavalid compares against check LFSR, then advances it. All issued → DRAIN.
- DRAIN: no commands; wait pend==0 → FIN.
- FIN: pulse done, → IDLE; busy low in same cycle as done.
- Mismatch: err_cnt+1 (saturating); err_addr latched only when err_cnt was 0; address tracked by a read-return index, not the issue index.
- abort in WRITE/READ: current held command completes if accepted that cycle, otherwise dropped; → DRAIN; aborted=1. abort in IDLE/DRAIN/FIN ignored except setting aborted in DRAIN. start while busy ignored.
- Reset: all outputs 0, state IDLE, pend 0; mid-run reset kills run with no done.

## Timing
- start at cycle 0 → busy=1 and first avm_write at cycle 1.
- Zero wait states: N writes in cycles 1..N; first read at N+1; back-to-back reads limited only by MAX_PEND vs. slave latency.
- Slave read latency L with MAX_PEND≥L+1: N reads issue in N cycles; done at cycle 2N+L+2.
- count==0: done at cycle 1, pass=1.
- Check compare registered: err_cnt updates one cycle after readdatavalid; FIN entered only after final compare lands.

## Structure
- Package soc_system_mem_tester_pkg: state enum, LFSR polynomial constant 32'h8020_0003 (taps 32,22,2,1), default-seed constant, next-state LFSR function.
- One sub-module: soc_system_mem_tester_lfsr (load/step/state), instantiated twice (write and check).

## Test plan
- Memory model L=1, no waitrequest, base=0, count=16, seed=32'h1 → 16 writes then 16 reads, pass=1, err_cnt=0, done at cycle 35.
- base=8190, count=4 → addresses 8190,8191,0,1 in both passes; pass=1.
- Model corrupts word at address 5 (bit 0 flip) and 9, count=16 → err_cnt=2, err_addr=5, pass=0.
- Random waitrequest (50%), readdata latency 3, MAX_PEND=4, count=64 → pend never exceeds 4, commands stable under stall, pass=1.
- abort during READ after 10 of 32 reads issued → no further commands, outstanding reads drained, done with aborted=1, pass=0.
- count=0, then start during busy, then reset_n low mid-WRITE → immediate done/pass=1; second start ignored; all outputs 0 after reset, no done.
